// File: rtl/ctrl_encode_def.sv
// ctrl_encode_def: next-PC select codes shared with the decoder, and fetch FSM states.
package ctrl_encode_def;
  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;
  typedef enum logic [1:0] {IF_IDLE, IF_REQ, IF_HOLD} if_state_e;
endpackage

// File: rtl/npc.sv
// npc: combinational next-PC mux over sequential, branch, jump and register targets.
module npc
  import ctrl_encode_def::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr,
  input  logic [31:0] rs_data,
  input  logic [1:0]  npc_op,
  output logic [31:0] npc
);
  logic [31:0] pc_plus4;
  assign pc_plus4 = pc + 32'd4;
  always_comb
    npc = npc_op == NPC_BRANCH ? pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00} :
          npc_op == NPC_JUMP   ? {pc_plus4[31:28], instr, 2'b00} :
          npc_op == NPC_JR     ? rs_data & ~32'd3 :
                                 pc_plus4;
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC register plus request/hold fetch FSM feeding the decoder, with retire counter.
module ifu_fetch
  import ctrl_encode_def::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  npc_op,
  input  logic [31:0] rs_data,
  input  logic        commit,
  output logic        misalign,
  output logic [31:0] retire_cnt
);
  if_state_e   state_q;
  logic [31:0] pc_q, instr_q, retire_q, npc_d;
  logic        misalign_q;
  npc u_npc (
    .pc(pc_q),
    .instr(instr_q[25:0]),
    .rs_data(rs_data),
    .npc_op(npc_op),
    .npc(npc_d)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state_q    <= IF_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      retire_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        IF_IDLE: state_q <= IF_REQ;
        IF_REQ:
          if (imem_ready) begin
            instr_q <= imem_rdata;
            state_q <= IF_HOLD;
          end
        IF_HOLD:
          if (commit) begin
            pc_q     <= npc_d;
            retire_q <= retire_q + 32'd1;
            state_q  <= IF_REQ;
            if (npc_op == NPC_JR && rs_data[1:0] != 2'b00) misalign_q <= 1'b1;
          end
        default: state_q <= IF_IDLE;
      endcase
    end
  assign imem_req    = state_q == IF_REQ;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = state_q == IF_HOLD;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign misalign    = misalign_q;
  assign retire_cnt  = retire_q;
endmodule
